pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage MIPS pipeline.
- Drives load enables for the PC and IF/ID registers, the bubble insert into ID/EX, and the IF/ID flush.
- Drives the operand-forwarding selects for the ID-stage operand muxes (MX1/MX2).
- Tracks the multi-cycle HI/LO multiply/divide unit with a busy counter and a two-state FSM.
- Sits beside the pipeline registers and consumes destination/control fields already carried by ID/EX, EX/MEM and MEM/WB.

Parameters:
MD_CYCLES, 4, cycles the mult/div unit is busy after issue (legal range 1..15)
STALL_CNT_W, 16, width of the saturating stall-cycle performance counter

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
ID_rs  in  5  rs field of the instruction in ID
ID_rt  in  5  rt field of the instruction in ID
ID_uses_rs  in  1  ID instruction reads rs
ID_uses_rt  in  1  ID instruction reads rt
ID_md_start  in  1  ID instruction is mult/multu/div/divu
ID_hilo_read  in  1  ID instruction is mfhi/mflo
ID_branch_taken  in  1  branch/jump resolved taken in ID
WriteDestination_EX  in  5  destination register in EX
EX_regwrite  in  1  EX instruction writes the register file
EX_load  in  1  EX instruction is a load
WriteDestination_MEM  in  5  destination register in MEM
MEM_regwrite  in  1  MEM instruction writes the register file
WriteDestination_WB  in  5  destination register in WB
WB_regwrite  in  1  WB instruction writes the register file
PC_LE  out  1  PC load enable
IFID_LE  out  1  IF/ID load enable
IFID_flush  out  1  load NOP into IF/ID on the next edge
IDEX_nop  out  1  force ID/EX control signals to zero (bubble)
fwd_rs_sel  out  2  00 regfile, 01 EX ALU_OUT, 10 MEM_MUX, 11 WB MEM_OUT
fwd_rt_sel  out  2  same encoding for rt
md_busy  out  1  mult/div unit is occupied
stall_cycles  out  STALL_CNT_W  saturating count of cycles with PC_LE=0

Behaviour:
Clocking and reset:
- One clock domain, clk.
- Reset is asynchronous and active-high.

Reset values:
- While reset is high: PC_LE=0, IFID_LE=0, IFID_flush=0, IDEX_nop=1, fwd selects=00, md_busy=0, stall_cycles=0, FSM=RUN, md counter=0.
- The first cycle after reset deasserts is RUN with no stall.

Hazard terms (all combinational):
- ex_hit = EX_regwrite && WriteDestination_EX!=0 && ((ID_uses_rs && ID_rs==WriteDestination_EX) || (ID_uses_rt && ID_rt==WriteDestination_EX)).
- load_stall = ex_hit && EX_load.
- md_stall = (state==MD_BUSY) && (ID_md_start || ID_hilo_read).
- stall = load_stall || md_stall.

Pipeline control outputs:
- On stall: PC_LE=0, IFID_LE=0, IDEX_nop=1, IFID_flush=0. ID_branch_taken is ignored during a stall because operands are stale; the branch re-evaluates on the next cycle.
- When not stalled: PC_LE=1, IFID_LE=1, IDEX_nop=0, IFID_flush=ID_branch_taken.
- A taken branch costs exactly one flushed slot.

Forwarding (per operand, independently):
- Source register 0 never forwards: select 00.
- Priority is EX (only when not EX_load) > MEM > WB > regfile.
- During a load_stall, both selects are 00.

Mult/div FSM (states RUN, MD_BUSY):
- RUN -> MD_BUSY on an edge where ID_md_start=1 and stall=0. At that edge, counter := MD_CYCLES-1.
- In MD_BUSY, the counter decrements each edge. On the edge where the counter is 0, the FSM returns to RUN.
- md_busy = (state==MD_BUSY).
- md_busy is high for exactly MD_CYCLES cycles after the issue edge.
- A stalled mfhi/mult in ID issues in the first cycle md_busy=0.
- With MD_CYCLES=1, md_busy is high for one cycle.
- A simultaneous return to RUN and ID_md_start in the same cycle: the ID instruction is stalled (state is still MD_BUSY in that cycle) and issues next cycle.

Stall counter:
- stall_cycles increments on every edge with PC_LE=0 and reset low.
- It saturates at all-ones and never wraps.

Reset mid-operation:
- Asserting reset in MD_BUSY immediately forces RUN and counter=0.
- Nothing resumes after reset.

Decomposition:
- Package hazard_pkg holds:
  - fwd select constants FWD_RF=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10, FWD_WB=2'b11
  - FSM state enum {RUN, MD_BUSY}
  - default MD_CYCLES
- One sub-module, md_busy_tracker, contains the FSM, the down-counter and md_busy.
- The top level holds the combinational hazard and forwarding logic and the stall counter.

Test Plan:
- Load-use: EX_load=1, WriteDestination_EX=8, EX_regwrite=1, ID_rs=8, ID_uses_rs=1 -> exactly one cycle with PC_LE=0, IFID_LE=0, IDEX_nop=1, fwd_rs_sel=00; next cycle with EX cleared -> PC_LE=1; stall_cycles=1.
- Forward priority: ID_rt=5, EX (non-load), MEM and WB all write r5 -> fwd_rt_sel=01; drop EX_regwrite -> 10; drop MEM_regwrite -> 11; ID_rt=0 with all matching -> 00.
- Branch: ID_branch_taken=1, no hazard -> IFID_flush=1 for one cycle, PC_LE=1; same with load_stall active -> IFID_flush=0.
- Mult/div: MD_CYCLES=4, ID_md_start issues, mfhi in ID the next cycle -> md_busy=1 for 4 cycles, mfhi stalled 4 cycles, issues in cycle 5; stall_cycles=4.
- Back-to-back mult: second ID_md_start held in ID during MD_BUSY -> stalled until md_busy=0, then re-enters MD_BUSY for another 4 cycles.
- Async reset in MD_BUSY (counter=2) mid-cycle -> md_busy=0, IDEX_nop=1 and stall_cycles=0 without waiting for a clock edge; after release -> RUN, PC_LE=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// mult/div FSM states and the default mult/div latency.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam int unsigned MD_CYCLES_DEFAULT = 4;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // Youngest matching producer wins; r0 is hardwired and never forwarded.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] src,
        input logic       ex_fwd,
        input logic [4:0] ex_dst,
        input logic       mem_wr,
        input logic [4:0] mem_dst,
        input logic       wb_wr,
        input logic [4:0] wb_dst
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != 5'd0) begin
            if (ex_fwd && ex_dst == src)
                sel = FWD_EX;
            else if (mem_wr && mem_dst == src)
                sel = FWD_MEM;
            else if (wb_wr && wb_dst == src)
                sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Occupancy tracker for the multi-cycle HI/LO unit: RUN/MD_BUSY FSM with a
// down-counter so md_busy stays high for exactly MD_CYCLES cycles per issue.
module md_busy_tracker
    import hazard_pkg::*;
#(
    parameter int unsigned MD_CYCLES = hazard_pkg::MD_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic issue,
    output logic md_busy
);

    localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 1);

    md_state_t  state, state_next;
    logic [3:0] cnt, cnt_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            RUN: begin
                if (issue) begin
                    state_next = MD_BUSY;
                    cnt_next   = MD_LOAD;
                end
            end
            MD_BUSY: begin
                if (cnt == 4'd0)
                    state_next = RUN;
                else
                    cnt_next = cnt - 4'd1;
            end
            default: state_next = RUN;
        endcase
    end

    assign md_busy = (state == MD_BUSY);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard detection, operand forwarding and stall accounting for the 5-stage
// MIPS pipeline; mult/div occupancy is delegated to md_busy_tracker.
module pipeline_hazard_ctrl #(
    parameter int unsigned MD_CYCLES   = hazard_pkg::MD_CYCLES_DEFAULT,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             ID_rs,
    input  logic [4:0]             ID_rt,
    input  logic                   ID_uses_rs,
    input  logic                   ID_uses_rt,
    input  logic                   ID_md_start,
    input  logic                   ID_hilo_read,
    input  logic                   ID_branch_taken,
    input  logic [4:0]             WriteDestination_EX,
    input  logic                   EX_regwrite,
    input  logic                   EX_load,
    input  logic [4:0]             WriteDestination_MEM,
    input  logic                   MEM_regwrite,
    input  logic [4:0]             WriteDestination_WB,
    input  logic                   WB_regwrite,
    output logic                   PC_LE,
    output logic                   IFID_LE,
    output logic                   IFID_flush,
    output logic                   IDEX_nop,
    output logic [1:0]             fwd_rs_sel,
    output logic [1:0]             fwd_rt_sel,
    output logic                   md_busy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    import hazard_pkg::*;

    logic ex_hit;
    logic load_stall;
    logic md_stall;
    logic stall;
    logic md_issue;
    logic ex_fwd;

    always_comb begin
        ex_hit = EX_regwrite && (WriteDestination_EX != 5'd0) &&
                 ((ID_uses_rs && ID_rs == WriteDestination_EX) ||
                  (ID_uses_rt && ID_rt == WriteDestination_EX));
        load_stall = ex_hit && EX_load;
        md_stall   = md_busy && (ID_md_start || ID_hilo_read);
        stall      = load_stall || md_stall;
        md_issue   = ID_md_start && !stall;
        ex_fwd     = EX_regwrite && !EX_load;
    end

    md_busy_tracker #(
        .MD_CYCLES(MD_CYCLES)
    ) u_md_busy_tracker (
        .clk     (clk),
        .reset   (reset),
        .issue   (md_issue),
        .md_busy (md_busy)
    );

    // Reset holds the pipeline frozen with a bubble in ID/EX; a stall freezes
    // PC and IF/ID and suppresses any branch flush since operands are stale.
    always_comb begin
        PC_LE      = 1'b0;
        IFID_LE    = 1'b0;
        IFID_flush = 1'b0;
        IDEX_nop   = 1'b1;
        fwd_rs_sel = FWD_RF;
        fwd_rt_sel = FWD_RF;
        if (!reset) begin
            if (!stall) begin
                PC_LE      = 1'b1;
                IFID_LE    = 1'b1;
                IDEX_nop   = 1'b0;
                IFID_flush = ID_branch_taken;
            end
            if (!load_stall) begin
                fwd_rs_sel = fwd_select(ID_rs, ex_fwd, WriteDestination_EX,
                                        MEM_regwrite, WriteDestination_MEM,
                                        WB_regwrite, WriteDestination_WB);
                fwd_rt_sel = fwd_select(ID_rt, ex_fwd, WriteDestination_EX,
                                        MEM_regwrite, WriteDestination_MEM,
                                        WB_regwrite, WriteDestination_WB);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cycles <= '0;
        else if (!PC_LE && stall_cycles != '1)
            stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: load-use, forwarding priority,
// branch flush, mult/div occupancy, async reset and stall-counter saturation.
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] ID_rs, ID_rt;
    logic       ID_uses_rs, ID_uses_rt;
    logic       ID_md_start, ID_hilo_read, ID_branch_taken;
    logic [4:0] WriteDestination_EX, WriteDestination_MEM, WriteDestination_WB;
    logic       EX_regwrite, EX_load, MEM_regwrite, WB_regwrite;
    logic       PC_LE, IFID_LE, IFID_flush, IDEX_nop;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;
    logic       md_busy;
    logic [3:0] stall_cycles;

    int passed = 0;
    int total  = 0;

    pipeline_hazard_ctrl #(
        .MD_CYCLES   (4),
        .STALL_CNT_W (4)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .ID_rs                (ID_rs),
        .ID_rt                (ID_rt),
        .ID_uses_rs           (ID_uses_rs),
        .ID_uses_rt           (ID_uses_rt),
        .ID_md_start          (ID_md_start),
        .ID_hilo_read         (ID_hilo_read),
        .ID_branch_taken      (ID_branch_taken),
        .WriteDestination_EX  (WriteDestination_EX),
        .EX_regwrite          (EX_regwrite),
        .EX_load              (EX_load),
        .WriteDestination_MEM (WriteDestination_MEM),
        .MEM_regwrite         (MEM_regwrite),
        .WriteDestination_WB  (WriteDestination_WB),
        .WB_regwrite          (WB_regwrite),
        .PC_LE                (PC_LE),
        .IFID_LE              (IFID_LE),
        .IFID_flush           (IFID_flush),
        .IDEX_nop             (IDEX_nop),
        .fwd_rs_sel           (fwd_rs_sel),
        .fwd_rt_sel           (fwd_rt_sel),
        .md_busy              (md_busy),
        .stall_cycles         (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_inputs();
        ID_rs = '0; ID_rt = '0; ID_uses_rs = 1'b0; ID_uses_rt = 1'b0;
        ID_md_start = 1'b0; ID_hilo_read = 1'b0; ID_branch_taken = 1'b0;
        WriteDestination_EX = '0; EX_regwrite = 1'b0; EX_load = 1'b0;
        WriteDestination_MEM = '0; MEM_regwrite = 1'b0;
        WriteDestination_WB = '0; WB_regwrite = 1'b0;
    endtask

    initial begin
        // Reset with a forwardable MEM producer and a taken branch present
        reset = 1'b1;
        clear_inputs();
        ID_rt = 5'd5; ID_uses_rt = 1'b1; MEM_regwrite = 1'b1; WriteDestination_MEM = 5'd5;
        ID_branch_taken = 1'b1;
        #2;
        check("rst_pc_le", PC_LE, 0);
        check("rst_ifid_le", IFID_LE, 0);
        check("rst_flush", IFID_flush, 0);
        check("rst_idex_nop", IDEX_nop, 1);
        check("rst_fwd_rt", fwd_rt_sel, 2'b00);
        check("rst_md_busy", md_busy, 0);
        check("rst_stall_cnt", stall_cycles, 0);

        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        #1;
        check("run_pc_le", PC_LE, 1);
        check("run_idex_nop", IDEX_nop, 0);
        check("run_stall_cnt", stall_cycles, 0);

        // Load-use on rs; MEM also produces rt but selects are forced to RF
        @(negedge clk);
        EX_load = 1'b1; EX_regwrite = 1'b1; WriteDestination_EX = 5'd8;
        ID_rs = 5'd8; ID_uses_rs = 1'b1;
        ID_rt = 5'd5; ID_uses_rt = 1'b1; MEM_regwrite = 1'b1; WriteDestination_MEM = 5'd5;
        #1;
        check("lu_pc_le", PC_LE, 0);
        check("lu_ifid_le", IFID_LE, 0);
        check("lu_idex_nop", IDEX_nop, 1);
        check("lu_fwd_rs", fwd_rs_sel, 2'b00);
        check("lu_fwd_rt", fwd_rt_sel, 2'b00);
        @(negedge clk);
        clear_inputs();
        #1;
        check("lu_after_pc_le", PC_LE, 1);
        check("lu_stall_cnt", stall_cycles, 1);

        // Forwarding priority on rt, rs left on an unrelated register
        @(negedge clk);
        ID_rt = 5'd5; ID_uses_rt = 1'b1; ID_rs = 5'd9; ID_uses_rs = 1'b1;
        EX_regwrite = 1'b1; WriteDestination_EX = 5'd5;
        MEM_regwrite = 1'b1; WriteDestination_MEM = 5'd5;
        WB_regwrite = 1'b1; WriteDestination_WB = 5'd5;
        #1;
        check("fwd_ex", fwd_rt_sel, 2'b01);
        check("fwd_rs_none", fwd_rs_sel, 2'b00);
        check("fwd_ex_no_stall", PC_LE, 1);
        @(negedge clk);
        EX_regwrite = 1'b0;
        #1;
        check("fwd_mem", fwd_rt_sel, 2'b10);
        @(negedge clk);
        MEM_regwrite = 1'b0;
        #1;
        check("fwd_wb", fwd_rt_sel, 2'b11);
        @(negedge clk);
        ID_rt = 5'd0;
        EX_regwrite = 1'b1; WriteDestination_EX = 5'd0;
        MEM_regwrite = 1'b1; WriteDestination_MEM = 5'd0;
        WB_regwrite = 1'b1; WriteDestination_WB = 5'd0;
        #1;
        check("fwd_r0", fwd_rt_sel, 2'b00);
        @(negedge clk);
        clear_inputs();
        ID_rs = 5'd7; ID_uses_rs = 1'b1;
        EX_regwrite = 1'b1; EX_load = 1'b1; WriteDestination_EX = 5'd3;
        MEM_regwrite = 1'b1; WriteDestination_MEM = 5'd7;
        #1;
        check("fwd_skip_ex_load", fwd_rs_sel, 2'b10);

        // Branch flush, then branch suppressed by a load stall
        @(negedge clk);
        clear_inputs();
        ID_branch_taken = 1'b1;
        #1;
        check("br_flush", IFID_flush, 1);
        check("br_pc_le", PC_LE, 1);
        @(negedge clk);
        EX_load = 1'b1; EX_regwrite = 1'b1; WriteDestination_EX = 5'd4;
        ID_rs = 5'd4; ID_uses_rs = 1'b1;
        #1;
        check("br_stall_flush", IFID_flush, 0);
        check("br_stall_pc_le", PC_LE, 0);
        #1;
        clear_inputs();
        @(negedge clk);
        #1;
        check("br_after_flush", IFID_flush, 0);
        check("br_stall_cnt", stall_cycles, 1);

        // mult issue followed by mfhi: 4 busy cycles, mfhi stalled throughout
        @(negedge clk);
        ID_md_start = 1'b1;
        #1;
        check("md_issue_pc_le", PC_LE, 1);
        check("md_issue_idle", md_busy, 0);
        @(negedge clk);
        ID_md_start = 1'b0; ID_hilo_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            check("md_busy_on", md_busy, 1);
            check("mfhi_stalled", PC_LE, 0);
        end
        @(negedge clk);
        #1;
        check("md_busy_off", md_busy, 0);
        check("mfhi_issues", PC_LE, 1);
        check("md_stall_cnt", stall_cycles, 5);

        // Back-to-back mult: second held in ID until the unit frees up
        @(negedge clk);
        ID_hilo_read = 1'b0; ID_md_start = 1'b1;
        #1;
        check("b2b_first_issue", PC_LE, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("b2b_busy", md_busy, 1);
            check("b2b_second_stalled", PC_LE, 0);
        end
        @(negedge clk);
        #1;
        check("b2b_free", md_busy, 0);
        check("b2b_second_issue", PC_LE, 1);
        check("b2b_stall_cnt", stall_cycles, 9);
        @(negedge clk);
        ID_md_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            check("b2b_busy2", md_busy, 1);
            check("b2b_busy2_pc_le", PC_LE, 1);
        end
        @(negedge clk);
        #1;
        check("b2b_done", md_busy, 0);
        check("b2b_done_cnt", stall_cycles, 9);

        // Async reset while busy with counter at 2
        @(negedge clk);
        ID_md_start = 1'b1;
        @(negedge clk);
        ID_md_start = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_md_busy", md_busy, 0);
        check("arst_idex_nop", IDEX_nop, 1);
        check("arst_pc_le", PC_LE, 0);
        check("arst_stall_cnt", stall_cycles, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("arst_rel_pc_le", PC_LE, 1);
        check("arst_rel_busy", md_busy, 0);
        @(negedge clk);
        #1;
        check("arst_no_resume", md_busy, 0);
        check("arst_rel_cnt", stall_cycles, 0);

        // Stall counter saturation (4-bit counter, 20 stalled edges)
        @(negedge clk);
        EX_load = 1'b1; EX_regwrite = 1'b1; WriteDestination_EX = 5'd2;
        ID_rt = 5'd2; ID_uses_rt = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("sat_pc_le", PC_LE, 0);
        check("sat_stall_cnt", stall_cycles, 4'hF);
        clear_inputs();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
